// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker
// Cursor position engine between the PS/2 packet decoder and the overlay logic.
// Each decoded movement packet is scaled by a programmable gain and added to
// fixed-point accumulators (pixel above, FRAC_BITS of sub-pixel below). The
// result is clamped or wrapped to the screen. PS/2 "Y up" is turned into
// screen "Y down" here. Button state and press/release/drag events are produced
// once per applied packet.
//
// Ports:
//   clk_i, reset_ni              clock, asynchronous active-low reset
//   packet_valid_i               a decoded packet is offered
//   packet_ready_o               tracker can take a packet (IDLE only)
//   x_velocity_i, y_velocity_i   signed deltas, +X right, +Y up
//   x_overflow_i, y_overflow_i   delta invalid, treated as zero
//   buttons_i                    {middle,right,left}
//   gain_i                       left shift applied to the deltas (0..3)
//   recenter_i                   load the home position at this edge
//   x_position_o, y_position_o   cursor pixel
//   buttons_o                    buttons of the last applied packet
//   press_o, release_o           one-cycle edge pulses per button
//   drag_o                       left held and the last packet moved the pixel
//   update_o                     one-cycle pulse when the pixel changed
module mouse_cursor_tracker #(
  parameter int COLUMNS   = 640,
  parameter int ROWS      = 480,
  parameter int VEL_WIDTH = 9,
  parameter int FRAC_BITS = 3,
  parameter int INIT_X    = COLUMNS / 2,
  parameter int INIT_Y    = ROWS / 2,
  parameter bit WRAP_EN   = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       packet_valid_i,
  output logic                       packet_ready_o,
  input  logic [VEL_WIDTH-1:0]       x_velocity_i,
  input  logic [VEL_WIDTH-1:0]       y_velocity_i,
  input  logic                       x_overflow_i,
  input  logic                       y_overflow_i,
  input  logic [2:0]                 buttons_i,
  input  logic [1:0]                 gain_i,
  input  logic                       recenter_i,
  output logic [$clog2(COLUMNS)-1:0] x_position_o,
  output logic [$clog2(ROWS)-1:0]    y_position_o,
  output logic [2:0]                 buttons_o,
  output logic [2:0]                 press_o,
  output logic [2:0]                 release_o,
  output logic                       drag_o,
  output logic                       update_o
);

  localparam int XW  = $clog2(COLUMNS);
  localparam int YW  = $clog2(ROWS);
  localparam int AXW = XW + FRAC_BITS;
  localparam int AYW = YW + FRAC_BITS;
  // A gain of 3 widens the delta by three bits.
  localparam int DW  = VEL_WIDTH + 3;
  localparam int AMW = (AXW > AYW) ? AXW : AYW;
  // Two spare bits: one for the sign, one so accumulator + delta never overflows.
  localparam int SW  = ((AMW > DW) ? AMW : DW) + 2;

  localparam logic [XW-1:0]  INIT_X_PIX = XW'(INIT_X);
  localparam logic [YW-1:0]  INIT_Y_PIX = YW'(INIT_Y);
  localparam logic [AXW-1:0] INIT_X_FX  = {INIT_X_PIX, {FRAC_BITS{1'b0}}};
  localparam logic [AYW-1:0] INIT_Y_FX  = {INIT_Y_PIX, {FRAC_BITS{1'b0}}};

  localparam logic signed [SW-1:0] X_MAX_FX  = SW'((COLUMNS - 1) << FRAC_BITS);
  localparam logic signed [SW-1:0] Y_MAX_FX  = SW'((ROWS - 1) << FRAC_BITS);
  localparam logic signed [SW-1:0] X_SPAN_FX = SW'(COLUMNS << FRAC_BITS);
  localparam logic signed [SW-1:0] Y_SPAN_FX = SW'(ROWS << FRAC_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCALE = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t                state_r, state_next_s;
  logic                  ready_r, accept_s;
  logic [VEL_WIDTH-1:0]  vel_x_r, vel_y_r;
  logic                  ovf_x_r, ovf_y_r;
  logic [2:0]            btn_cap_r;
  logic [1:0]            gain_r;
  logic [DW-1:0]         ext_x_s, ext_y_s;
  logic [DW-1:0]         dx_r, dy_r;
  logic [AXW-1:0]        acc_x_r, new_x_s;
  logic [AYW-1:0]        acc_y_r, new_y_s;
  logic signed [SW-1:0]  sum_x_s, sum_y_s;
  logic                  moved_s, home_moved_s;
  logic [2:0]            buttons_r, press_r, release_r;
  logic                  drag_r, update_r;

  // Fold a raw accumulator sum back onto the screen. One correction is enough
  // because a single delta is always smaller than the screen span.
  function automatic logic signed [SW-1:0] fit_axis(
    input logic signed [SW-1:0] v,
    input logic signed [SW-1:0] max_fx,
    input logic signed [SW-1:0] span_fx
  );
    logic signed [SW-1:0] r;
    if (WRAP_EN) begin
      if (v[SW-1]) begin
        r = v + span_fx;
      end else if (v >= span_fx) begin
        r = v - span_fx;
      end else begin
        r = v;
      end
    end else begin
      if (v[SW-1]) begin
        r = {SW{1'b0}};
      end else if (v > max_fx) begin
        r = max_fx;
      end else begin
        r = v;
      end
    end
    return r;
  endfunction

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and handshake decode
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (packet_valid_i) begin
          state_next_s = ST_SCALE;
          accept_s     = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCALE: state_next_s = ST_APPLY;
      ST_APPLY: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Registered ready: high exactly while the FSM sits in IDLE
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= (state_next_s == ST_IDLE);
    end
  end

  // Packet capture on handshake
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      vel_x_r   <= {VEL_WIDTH{1'b0}};
      vel_y_r   <= {VEL_WIDTH{1'b0}};
      ovf_x_r   <= 1'b0;
      ovf_y_r   <= 1'b0;
      btn_cap_r <= 3'b000;
      gain_r    <= 2'b00;
    end else if (accept_s) begin
      vel_x_r   <= x_velocity_i;
      vel_y_r   <= y_velocity_i;
      ovf_x_r   <= x_overflow_i;
      ovf_y_r   <= y_overflow_i;
      btn_cap_r <= buttons_i;
      gain_r    <= gain_i;
    end
  end

  // Sign-extend the captured velocities to the scaled-delta width
  always_comb begin
    ext_x_s = {{(DW-VEL_WIDTH){vel_x_r[VEL_WIDTH-1]}}, vel_x_r};
    ext_y_s = {{(DW-VEL_WIDTH){vel_y_r[VEL_WIDTH-1]}}, vel_y_r};
  end

  // Scaled deltas, registered in SCALE; an overflowed axis contributes nothing
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dx_r <= {DW{1'b0}};
      dy_r <= {DW{1'b0}};
    end else if (state_r == ST_SCALE) begin
      dx_r <= ovf_x_r ? {DW{1'b0}} : (ext_x_s << gain_r);
      dy_r <= ovf_y_r ? {DW{1'b0}} : (ext_y_s << gain_r);
    end
  end

  // Candidate accumulator values and pixel-change detection.
  // Y is subtracted: mouse "up" is a smaller screen row.
  always_comb begin
    sum_x_s = $signed({{(SW-AXW){1'b0}}, acc_x_r}) + $signed({{(SW-DW){dx_r[DW-1]}}, dx_r});
    sum_y_s = $signed({{(SW-AYW){1'b0}}, acc_y_r}) - $signed({{(SW-DW){dy_r[DW-1]}}, dy_r});
    new_x_s = AXW'(fit_axis(sum_x_s, X_MAX_FX, X_SPAN_FX));
    new_y_s = AYW'(fit_axis(sum_y_s, Y_MAX_FX, Y_SPAN_FX));
    moved_s = (new_x_s[AXW-1:FRAC_BITS] != acc_x_r[AXW-1:FRAC_BITS]) ||
              (new_y_s[AYW-1:FRAC_BITS] != acc_y_r[AYW-1:FRAC_BITS]);
    home_moved_s = (acc_x_r[AXW-1:FRAC_BITS] != INIT_X_PIX) ||
                   (acc_y_r[AYW-1:FRAC_BITS] != INIT_Y_PIX);
  end

  // Accumulators, button state and event pulses. Recenter overrides the
  // position part of APPLY, while the packet's buttons still take effect.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      acc_x_r   <= INIT_X_FX;
      acc_y_r   <= INIT_Y_FX;
      buttons_r <= 3'b000;
      press_r   <= 3'b000;
      release_r <= 3'b000;
      drag_r    <= 1'b0;
      update_r  <= 1'b0;
    end else begin
      press_r   <= 3'b000;
      release_r <= 3'b000;
      update_r  <= 1'b0;
      if (state_r == ST_APPLY) begin
        buttons_r <= btn_cap_r;
        press_r   <= btn_cap_r & ~buttons_r;
        release_r <= buttons_r & ~btn_cap_r;
      end
      if (recenter_i) begin
        acc_x_r  <= INIT_X_FX;
        acc_y_r  <= INIT_Y_FX;
        drag_r   <= 1'b0;
        update_r <= home_moved_s;
      end else if (state_r == ST_APPLY) begin
        acc_x_r  <= new_x_s;
        acc_y_r  <= new_y_s;
        drag_r   <= btn_cap_r[0] & moved_s;
        update_r <= moved_s;
      end
    end
  end

  assign packet_ready_o = ready_r;
  assign x_position_o   = acc_x_r[AXW-1:FRAC_BITS];
  assign y_position_o   = acc_y_r[AYW-1:FRAC_BITS];
  assign buttons_o      = buttons_r;
  assign press_o        = press_r;
  assign release_o      = release_r;
  assign drag_o         = drag_r;
  assign update_o       = update_r;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Bench for mouse_cursor_tracker: a clamping and a wrapping instance share one
// stimulus stream. A directed vector table with hand-derived expectations,
// randomized packets checked against a pixel-arithmetic model, and hand-written
// sequences for recenter-during-packet and reset-during-APPLY.
module tb_mouse_cursor_tracker;

  localparam int COLS   = 640;
  localparam int ROWS_P = 480;
  localparam int VW     = 9;
  localparam int SUB    = 8;     // sub-pixel steps per pixel
  localparam int HOME_X = 320;
  localparam int HOME_Y = 240;
  localparam int NV     = 22;

  typedef struct {
    bit         rec;
    int         vx, vy;
    bit         ox, oy;
    logic [2:0] btn;
    int         g;
    int         xc, yc, xw, yw;
    bit         uc, uw;
    logic [2:0] pr, rl;
    bit         dr;
  } vec_t;

  logic            clk_i, reset_ni, valid, xo, yo, recenter;
  logic [VW-1:0]   xv, yv;
  logic [2:0]      btn_i;
  logic [1:0]      gain;
  logic            ready_s [2];
  logic [9:0]      xpos_s  [2];
  logic [8:0]      ypos_s  [2];
  logic [2:0]      btn_o_s [2];
  logic [2:0]      press_s [2];
  logic [2:0]      rel_s   [2];
  logic            drag_s  [2];
  logic            upd_s   [2];

  int         tests = 0;
  int         fails = 0;
  int         mx [2], my [2];
  bit         mupd [2], mdrag [2];
  logic [2:0] mbtn, mpress, mrel;
  vec_t       vecs [NV];

  mouse_cursor_tracker #(.WRAP_EN(1'b0)) dut_clamp (
    .clk_i(clk_i), .reset_ni(reset_ni), .packet_valid_i(valid), .packet_ready_o(ready_s[0]),
    .x_velocity_i(xv), .y_velocity_i(yv), .x_overflow_i(xo), .y_overflow_i(yo),
    .buttons_i(btn_i), .gain_i(gain), .recenter_i(recenter),
    .x_position_o(xpos_s[0]), .y_position_o(ypos_s[0]), .buttons_o(btn_o_s[0]),
    .press_o(press_s[0]), .release_o(rel_s[0]), .drag_o(drag_s[0]), .update_o(upd_s[0]));

  mouse_cursor_tracker #(.WRAP_EN(1'b1)) dut_wrap (
    .clk_i(clk_i), .reset_ni(reset_ni), .packet_valid_i(valid), .packet_ready_o(ready_s[1]),
    .x_velocity_i(xv), .y_velocity_i(yv), .x_overflow_i(xo), .y_overflow_i(yo),
    .buttons_i(btn_i), .gain_i(gain), .recenter_i(recenter),
    .x_position_o(xpos_s[1]), .y_position_o(ypos_s[1]), .buttons_o(btn_o_s[1]),
    .press_o(press_s[1]), .release_o(rel_s[1]), .drag_o(drag_s[1]), .update_o(upd_s[1]));

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: move one axis in sub-pixel units, then clamp or wrap to the screen.
  function automatic int move_axis(input int a, input int d, input int dim, input bit wrap);
    int r, span;
    r    = a + d;
    span = dim * SUB;
    if (wrap) r = ((r % span) + span) % span;
    else if (r < 0) r = 0;
    else if (r > (dim - 1) * SUB) r = (dim - 1) * SUB;
    return r;
  endfunction

  task automatic model_home_reset();
    for (int w = 0; w < 2; w++) begin
      mx[w] = HOME_X * SUB; my[w] = HOME_Y * SUB; mupd[w] = 1'b0; mdrag[w] = 1'b0;
    end
    mbtn = 3'b000; mpress = 3'b000; mrel = 3'b000;
  endtask

  task automatic model_apply(input int vx, input int vy, input bit ox, input bit oy,
                             input logic [2:0] btn, input int g);
    int dx, dy, nx, ny;
    dx = ox ? 0 : vx * (1 << g);
    dy = oy ? 0 : vy * (1 << g);
    for (int w = 0; w < 2; w++) begin
      nx = move_axis(mx[w], dx, COLS, w != 0);
      ny = move_axis(my[w], -dy, ROWS_P, w != 0);
      mupd[w]  = (nx / SUB != mx[w] / SUB) || (ny / SUB != my[w] / SUB);
      mdrag[w] = btn[0] && mupd[w];
      mx[w] = nx; my[w] = ny;
    end
    mpress = btn & ~mbtn;
    mrel   = mbtn & ~btn;
    mbtn   = btn;
  endtask

  task automatic check_model(input string tag);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("%s x w%0d", tag, w), int'(xpos_s[w]), mx[w] / SUB);
      chk($sformatf("%s y w%0d", tag, w), int'(ypos_s[w]), my[w] / SUB);
      chk($sformatf("%s update w%0d", tag, w), int'(upd_s[w]), int'(mupd[w]));
      chk($sformatf("%s drag w%0d", tag, w), int'(drag_s[w]), int'(mdrag[w]));
      chk($sformatf("%s buttons w%0d", tag, w), int'(btn_o_s[w]), int'(mbtn));
      chk($sformatf("%s press w%0d", tag, w), int'(press_s[w]), int'(mpress));
      chk($sformatf("%s release w%0d", tag, w), int'(rel_s[w]), int'(mrel));
    end
  endtask

  // One cycle later the pulses are gone and drag holds.
  task automatic check_clear(input string tag);
    @(posedge clk_i); #1;
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("%s upd_clr w%0d", tag, w), int'(upd_s[w]), 0);
      chk($sformatf("%s press_clr w%0d", tag, w), int'(press_s[w]), 0);
      chk($sformatf("%s rel_clr w%0d", tag, w), int'(rel_s[w]), 0);
      chk($sformatf("%s drag_hold w%0d", tag, w), int'(drag_s[w]), int'(mdrag[w]));
    end
    mupd[0] = 1'b0; mupd[1] = 1'b0; mpress = 3'b000; mrel = 3'b000;
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (ready_s[0] !== 1'b1 && n < 10) begin
      @(posedge clk_i); #1;
      n++;
    end
    ok = (n < 10);
    if (!ok) chk("ready_wait", int'(ready_s[0]), 1);
  endtask

  task automatic do_recenter(input string tag);
    recenter = 1'b1;
    @(posedge clk_i); #1;
    recenter = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mupd[w]  = (mx[w] / SUB != HOME_X) || (my[w] / SUB != HOME_Y);
      mx[w] = HOME_X * SUB; my[w] = HOME_Y * SUB; mdrag[w] = 1'b0;
    end
    mpress = 3'b000; mrel = 3'b000;
    check_model({tag, " rec"});
    check_clear({tag, " rec"});
  endtask

  // Full packet: handshake, a stray valid while busy, ready timing, model update.
  task automatic send(input int vx, input int vy, input bit ox, input bit oy,
                      input logic [2:0] btn, input int g);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    valid = 1'b1; xv = VW'(vx); yv = VW'(vy); xo = ox; yo = oy; btn_i = btn; gain = 2'(g);
    @(posedge clk_i); #1;
    xv = VW'(vx + 77); yv = VW'(vy - 33); btn_i = ~btn; gain = 2'(g + 1);
    for (int w = 0; w < 2; w++) chk($sformatf("ready_scale w%0d", w), int'(ready_s[w]), 0);
    @(posedge clk_i); #1;
    valid = 1'b0;
    for (int w = 0; w < 2; w++) chk($sformatf("ready_apply w%0d", w), int'(ready_s[w]), 0);
    @(posedge clk_i); #1;
    for (int w = 0; w < 2; w++) chk($sformatf("ready_done w%0d", w), int'(ready_s[w]), 1);
    model_apply(vx, vy, ox, oy, btn, g);
  endtask

  function automatic vec_t mk(input bit rec, input int vx, input int vy, input bit ox,
                              input bit oy, input logic [2:0] btn, input int g,
                              input int xc, input int yc, input int xw, input int yw,
                              input bit uc, input bit uw, input logic [2:0] pr,
                              input logic [2:0] rl, input bit dr);
    vec_t v;
    v.rec = rec; v.vx = vx; v.vy = vy; v.ox = ox; v.oy = oy; v.btn = btn; v.g = g;
    v.xc = xc; v.yc = yc; v.xw = xw; v.yw = yw; v.uc = uc; v.uw = uw;
    v.pr = pr; v.rl = rl; v.dr = dr;
    return v;
  endfunction

  initial begin
    bit ok;
    int vx, vy, exp_upd;
    logic [2:0] rb;

    reset_ni = 1'b0; valid = 1'b0; xv = '0; yv = '0; xo = 1'b0; yo = 1'b0;
    btn_i = 3'b000; gain = 2'd0; recenter = 1'b0;
    model_home_reset();

    // Directed vectors: expectations are hand-derived pixel positions.
    vecs[0]  = mk(1'b0,    5,  10, 1'b0, 1'b0, 3'b000, 3, 325, 230, 325, 230, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
    vecs[1]  = mk(1'b0,  255, 225, 1'b0, 1'b0, 3'b000, 3, 580,   5, 580,   5, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
    vecs[2]  = mk(1'b0,   50,   0, 1'b0, 1'b0, 3'b000, 3, 630,   5, 630,   5, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
    vecs[3]  = mk(1'b0,   20,  20, 1'b0, 1'b0, 3'b000, 3, 639,   0,  10, 465, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
    vecs[4]  = mk(1'b0,   20,  20, 1'b0, 1'b0, 3'b000, 3, 639,   0,  30, 445, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    vecs[5]  = mk(1'b1, -255, 238, 1'b0, 1'b0, 3'b000, 3,  65,   2,  65,   2, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
    vecs[6]  = mk(1'b0,  -62,   0, 1'b0, 1'b0, 3'b000, 3,   3,   2,   3,   2, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
    vecs[7]  = mk(1'b0,   -8,   5, 1'b0, 1'b0, 3'b000, 3,   0,   0, 635, 477, 1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
    for (int k = 0; k < 8; k++)
      vecs[8+k] = mk(k == 0, 1, 0, 1'b0, 1'b0, 3'b000, 0, (k == 7) ? 321 : 320, 240,
                     (k == 7) ? 321 : 320, 240, k == 7, k == 7, 3'b000, 3'b000, 1'b0);
    vecs[16] = mk(1'b1,    4,   0, 1'b0, 1'b0, 3'b001, 3, 324, 240, 324, 240, 1'b1, 1'b1, 3'b001, 3'b000, 1'b1);
    vecs[17] = mk(1'b0,    0,   0, 1'b0, 1'b0, 3'b000, 3, 324, 240, 324, 240, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0);
    vecs[18] = mk(1'b0,  100,   0, 1'b1, 1'b0, 3'b000, 3, 324, 240, 324, 240, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
    vecs[19] = mk(1'b0,    0,   0, 1'b0, 1'b0, 3'b001, 3, 324, 240, 324, 240, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0);
    vecs[20] = mk(1'b0,    0,  -1, 1'b0, 1'b0, 3'b011, 3, 324, 241, 324, 241, 1'b1, 1'b1, 3'b010, 3'b000, 1'b1);
    vecs[21] = mk(1'b0,    0,  50, 1'b0, 1'b1, 3'b110, 3, 324, 241, 324, 241, 1'b0, 1'b0, 3'b100, 3'b001, 1'b0);

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    for (int w = 0; w < 2; w++) chk($sformatf("reset ready w%0d", w), int'(ready_s[w]), 1);
    check_model("reset");
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rec) do_recenter($sformatf("v%0d", i));
      send(vecs[i].vx, vecs[i].vy, vecs[i].ox, vecs[i].oy, vecs[i].btn, vecs[i].g);
      for (int w = 0; w < 2; w++) begin
        chk($sformatf("v%0d x w%0d", i, w), int'(xpos_s[w]), (w != 0) ? vecs[i].xw : vecs[i].xc);
        chk($sformatf("v%0d y w%0d", i, w), int'(ypos_s[w]), (w != 0) ? vecs[i].yw : vecs[i].yc);
        chk($sformatf("v%0d update w%0d", i, w), int'(upd_s[w]), int'((w != 0) ? vecs[i].uw : vecs[i].uc));
        chk($sformatf("v%0d buttons w%0d", i, w), int'(btn_o_s[w]), int'(vecs[i].btn));
        chk($sformatf("v%0d press w%0d", i, w), int'(press_s[w]), int'(vecs[i].pr));
        chk($sformatf("v%0d release w%0d", i, w), int'(rel_s[w]), int'(vecs[i].rl));
        chk($sformatf("v%0d drag w%0d", i, w), int'(drag_s[w]), int'(vecs[i].dr));
      end
      check_clear($sformatf("v%0d", i));
    end

    // Randomized packets against the model
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        do_recenter($sformatf("r%0d", i));
      end else begin
        if ($urandom_range(0, 1) == 0) begin
          vx = int'($urandom_range(0, 511)) - 256; vy = int'($urandom_range(0, 511)) - 256;
        end else begin
          vx = int'($urandom_range(0, 40)) - 20; vy = int'($urandom_range(0, 40)) - 20;
        end
        send(vx, vy, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
             3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        check_model($sformatf("r%0d", i));
        check_clear($sformatf("r%0d", i));
      end
    end

    // Recenter held through SCALE and APPLY: position goes home, buttons still latch.
    send(13, -7, 1'b0, 1'b0, 3'b110, 3);
    check_model("pre_rec");
    check_clear("pre_rec");
    wait_ready(ok);
    if (ok) begin
      exp_upd = ((mx[0] / SUB != HOME_X) || (my[0] / SUB != HOME_Y)) ? 1 : 0;
      valid = 1'b1; xv = VW'(50); yv = '0; xo = 1'b0; yo = 1'b0; btn_i = 3'b001; gain = 2'd3;
      @(posedge clk_i); #1;
      valid = 1'b0; recenter = 1'b1;
      @(posedge clk_i); #1;
      chk("rec_scale update", int'(upd_s[0]), exp_upd);
      @(posedge clk_i); #1;
      recenter = 1'b0;
      rb = mbtn;
      for (int w = 0; w < 2; w++) begin
        mx[w] = HOME_X * SUB; my[w] = HOME_Y * SUB; mdrag[w] = 1'b0; mupd[w] = 1'b0;
      end
      mpress = 3'b001 & ~rb; mrel = rb & ~3'b001; mbtn = 3'b001;
      check_model("rec_apply");
      check_clear("rec_apply");
    end

    // Reset asserted while a packet is in APPLY
    send(9, 4, 1'b0, 1'b0, 3'b101, 3);
    check_model("pre_rst");
    check_clear("pre_rst");
    wait_ready(ok);
    if (ok) begin
      valid = 1'b1; xv = VW'(7); yv = VW'(3); xo = 1'b0; yo = 1'b0; btn_i = 3'b011; gain = 2'd3;
      @(posedge clk_i); #1;
      valid = 1'b0;
      @(posedge clk_i); #1;
      reset_ni = 1'b0;
      #2;
      model_home_reset();
      for (int w = 0; w < 2; w++) chk($sformatf("rst_async ready w%0d", w), int'(ready_s[w]), 1);
      check_model("rst_async");
      @(posedge clk_i); #1;
      reset_ni = 1'b1;
      @(posedge clk_i); #1;
      check_model("rst_after");
      send(-3, 2, 1'b0, 1'b0, 3'b100, 3);
      check_model("rst_recover");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mouse_cursor_tracker.md
Name: mouse_cursor_tracker

Overview:
Parametrised cursor position engine between the PS/2 mouse packet decoder and the sand-painting / VGA overlay logic. It accepts decoded movement packets over a valid/ready handshake and applies a programmable gain with sub-pixel fixed-point accumulation. It clamps or wraps the result to the screen, applies the PS/2 Y-up to screen Y-down conversion, and produces debounced-by-packet button state with press/release/drag events.

Parameters:
COLUMNS, 640, screen width in pixels
ROWS, 480, screen height in pixels
VEL_WIDTH, 9, width of two's-complement velocity inputs
FRAC_BITS, 3, sub-pixel fraction bits of the internal accumulators
INIT_X, COLUMNS/2, reset/recenter column
INIT_Y, ROWS/2, reset/recenter row
WRAP_EN, 0, 0 = clamp at edges, 1 = wrap around edges
Constraint: 2^(VEL_WIDTH+2) <= min(COLUMNS,ROWS)*2^FRAC_BITS. This guarantees a single wrap correction suffices.

Ports:
clk_i  in  1  system clock
reset_ni  in  1  asynchronous, active-low reset
packet_valid_i  in  1  packet present
packet_ready_o  out  1  tracker can accept a packet
x_velocity_i  in  VEL_WIDTH  signed X delta; positive = right
y_velocity_i  in  VEL_WIDTH  signed Y delta; positive = up (PS/2 convention)
x_overflow_i  in  1  X delta invalid
y_overflow_i  in  1  Y delta invalid
buttons_i  in  3  {middle,right,left}
gain_i  in  2  delta shift 0..3, sampled with the packet
recenter_i  in  1  synchronous recenter request
x_position_o  out  $clog2(COLUMNS)  cursor column
y_position_o  out  $clog2(ROWS)  cursor row
buttons_o  out  3  button state from the last applied packet
press_o  out  3  one-cycle rising-edge pulses per button
release_o  out  3  one-cycle falling-edge pulses per button
drag_o  out  1  left held and position changed by the last packet
update_o  out  1  one-cycle pulse: position changed

Behaviour:
- Reset (reset_ni low, asynchronous):
  - FSM goes to IDLE.
  - Accumulators load INIT_X/INIT_Y with fraction 0.
  - buttons_o, press_o, release_o, drag_o and update_o are 0.
  - packet_ready_o is 1 once in IDLE.
  - Reset mid-packet discards the in-flight packet.
- FSM states IDLE -> SCALE -> APPLY -> IDLE:
  - packet_ready_o = 1 only in IDLE.
  - A handshake (valid & ready at a rising edge) captures the velocities, overflow flags, buttons and gain, and moves the FSM to SCALE.
  - SCALE registers the deltas: dx = sext(x_velocity_i) << gain, forced to 0 if x_overflow_i; dy likewise.
  - APPLY updates accumulators, buttons and events, then returns to IDLE.
  - Packet accepted at edge k: outputs valid after edge k+2. Next accept is possible at edge k+3 at the earliest. Maximum throughput is 1 packet per 3 cycles.
- Accumulator format: pixel index in the upper bits, FRAC_BITS fraction below. Output position = accumulator >> FRAC_BITS.
- Scaling: one velocity count = 2^gain / 2^FRAC_BITS pixels. Defaults: gain 3 = 1 px/count; gain 0 = 1/8 px/count.
- X update: ax' = ax + dx. Y update: ay' = ay - dy.
  - Compute with signed width wide enough for no overflow.
- Clamp mode (WRAP_EN = 0):
  - Result < 0 -> 0 with fraction 0.
  - Result > (MAX << FRAC_BITS) -> MAX << FRAC_BITS, fraction 0. MAX = COLUMNS-1 or ROWS-1.
- Wrap mode (WRAP_EN = 1), with span = dimension << FRAC_BITS:
  - Result < 0 -> add span.
  - Result >= span -> subtract span.
- update_o pulses for one cycle after APPLY iff either pixel coordinate changed. A fraction-only change does not pulse.
- Buttons at APPLY:
  - buttons_o <= captured buttons.
  - press_o = new & ~old; release_o = old & ~new. Both are one-cycle pulses, otherwise 0.
- drag_o is registered at APPLY as captured left & pixel position changed. It holds until the next APPLY or recenter.
- Recenter:
  - recenter_i high at any edge loads INIT_X/INIT_Y (fraction 0), clears drag_o and pulses update_o if the position changed.
  - Recenter in the same cycle as APPLY: recenter wins for position; buttons and press/release from the packet still apply.
  - Recenter does not change FSM state or packet_ready_o.
- packet_valid_i while not ready is ignored. The source must hold it until accepted.

Test Plan:
- Reset, then gain 3, x_velocity +5, y_velocity +10 -> packet_ready_o low for 2 cycles; then x = 325, y = 230, update_o pulses once.
- Clamp: x at 630, y at 5; send dx +20, dy +20 at gain 3 -> x = 639, y = 0; repeat the packet -> positions unchanged, no update_o.
- WRAP_EN = 1: x 630, dx +20 -> x = 10; x 3, dx -8 -> x = 635; y 2, dy +5 -> y = 477.
- Gain 0: eight packets of dx +1 from x 320 -> x stays 320 for packets 1-7 and becomes 321 after packet 8; update_o pulses only once.
- Buttons: packet buttons 001 with dx +4 -> press_o = 001, drag_o = 1; next packet buttons 000, dx 0 -> release_o = 001, drag_o = 0; x_overflow_i set with dx +100 -> x unchanged.
- Recenter_i during SCALE with a pending dx +50 -> position 320/240; packet buttons still latched. Deassert reset_ni mid-APPLY -> all outputs return to reset values asynchronously.
